sensor_debounce: RTL and testbench
==================================

// Module: sensor_debounce
// PURPOSE
//  Upstream conditioning stage for the four object-detection sensors.
//  Synchronises each raw asynchronous sensor line into clk, debounces it
//  against a prescaled sample tick and drives the clean front/left/right/back
//  sensor levels consumed by the object detector. Also flags when outputs are
//  trustworthy (sensor_valid) and pulses per-sensor change events.
// PARAMETERS
//  SYNC_STAGES   2    flops in each synchroniser chain (>=2)
//  PRESCALE      100  clk cycles per sample tick (>=1)
//  PRESCALE_W    7    width of prescale counter, 2**PRESCALE_W >= PRESCALE
//  DEBOUNCE_CNT  16   consecutive mismatching ticks required to accept a new level (>=1)
//  CNT_W         5    width of debounce counters, 2**CNT_W > DEBOUNCE_CNT
// PORTS
//  clk            in   1  system clock, all logic on rising edge
//  reset          in   1  asynchronous, active-low reset (0 = reset)
//  front_raw      in   1  raw front sensor, asynchronous
//  left_raw       in   1  raw left sensor, asynchronous
//  right_raw      in   1  raw right sensor, asynchronous
//  back_raw       in   1  raw back sensor, asynchronous
//  front_sensor   out  1  debounced front level
//  left_sensor    out  1  debounced left level
//  right_sensor   out  1  debounced right level
//  back_sensor    out  1  debounced back level
//  sensor_valid   out  1  1 once initial debounce window complete
//  sensor_change  out  4  one-cycle pulse per flip, {front,left,right,back}
// BEHAVIOUR
//  Reset (reset=0, async): all sync flops, counters, outputs = 0; sensor_valid=0;
//   sensor_change=0; FSM -> INIT; prescale counter = 0.
//  Prescaler: counts 0..PRESCALE-1, wraps to 0; tick=1 for the one cycle count==PRESCALE-1.
//   PRESCALE=1 -> tick every cycle. First tick PRESCALE cycles after reset release.
//  Sync: sN = raw delayed SYNC_STAGES clk; only sN is used downstream.
//  FSM INIT: global init counter increments on each tick; on the DEBOUNCE_CNT-th tick
//   every stable output loads its sN, sensor_change stays 0, sensor_valid goes 1 next
//   cycle, FSM -> RUN. Per-sensor counters held at 0 in INIT.
//  FSM RUN (per sensor, independent):
//   - sN == stable: counter cleared to 0 every cycle (tick or not).
//   - sN != stable on tick: counter+1; when counter was DEBOUNCE_CNT-1, stable<=sN,
//     counter<=0, that sensor_change bit =1 for exactly that following cycle.
//   - sN != stable, no tick: counter holds.
//   - glitch: any cycle with sN back equal to stable clears the counter (restart).
//  Latency: new level held steadily appears at output after SYNC_STAGES clk plus
//   DEBOUNCE_CNT ticks (ticks counted from first tick where mismatch seen), +1 clk reg.
//  Simultaneous flips: multiple sensor_change bits may assert in the same cycle.
//  Counter never exceeds DEBOUNCE_CNT-1; no wrap. RUN is exited only by reset.
//  Reset mid-debounce: pending counts discarded, outputs 0, INIT repeats in full.
//  All outputs registered; no combinational path raw -> output.
// TESTING (bench uses PRESCALE=4, DEBOUNCE_CNT=3, SYNC_STAGES=2)
//  1 reset=0 then 1, all raw=0 -> outputs 0, sensor_valid=1 after 12 clk (+1 reg), change=0.
//  2 RUN, front_raw 0->1 held -> front_sensor=1 after 3 ticks, sensor_change=4'b1000 1 clk.
//  3 RUN, left_raw high for 6 clk then low -> left_sensor stays 0, change never set.
//  4 front_raw and right_raw rise same clk -> both flip same cycle, sensor_change=4'b1010.
//  5 back_raw=1 during INIT -> back_sensor=1 at valid, no change pulse; reset=0 mid-
//    debounce of front -> all outputs 0 immediately, sensor_valid=0, INIT restarts.

Source files
------------

// File: rtl/sensor_debounce.sv
// Four-channel sensor conditioner: synchronise, debounce on a prescaled tick,
// flag validity after the initial window and pulse per-sensor change events.
module sensor_debounce #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned PRESCALE     = 100,
  parameter int unsigned PRESCALE_W   = 7,
  parameter int unsigned DEBOUNCE_CNT = 16,
  parameter int unsigned CNT_W        = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       front_raw,
  input  logic       left_raw,
  input  logic       right_raw,
  input  logic       back_raw,
  output logic       front_sensor,
  output logic       left_sensor,
  output logic       right_sensor,
  output logic       back_sensor,
  output logic       sensor_valid,
  output logic [3:0] sensor_change
);

  localparam int unsigned NS = 4;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [NS-1:0]         w_raw;
  logic [NS-1:0]         r_sync [SYNC_STAGES];
  logic [NS-1:0]         w_sn;
  logic [PRESCALE_W-1:0] r_presc;
  logic                  w_tick;
  logic [CNT_W-1:0]      r_init_cnt;
  logic [CNT_W-1:0]      w_init_nxt;
  logic [CNT_W-1:0]      r_cnt [NS];
  logic [CNT_W-1:0]      w_cnt_nxt [NS];
  logic [NS-1:0]         r_stable;
  logic [NS-1:0]         w_stable_nxt;
  logic                  r_valid;
  logic                  w_valid_nxt;
  logic [NS-1:0]         r_change;
  logic [NS-1:0]         w_change_nxt;

  // Bit order {front,left,right,back} matches sensor_change.
  assign w_raw = {front_raw, left_raw, right_raw, back_raw};
  assign w_sn  = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= w_raw;
      for (int i = 1; i < int'(SYNC_STAGES); i++) r_sync[i] <= r_sync[i-1];
    end
  end

  // Sample tick: one cycle in every PRESCALE.
  assign w_tick = (r_presc == PRESCALE_W'(PRESCALE - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_presc <= '0;
    else        r_presc <= w_tick ? '0 : r_presc + PRESCALE_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_INIT;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_init_nxt   = r_init_cnt;
    w_stable_nxt = r_stable;
    w_valid_nxt  = r_valid;
    w_change_nxt = '0;
    for (int i = 0; i < int'(NS); i++) w_cnt_nxt[i] = r_cnt[i];
    case (r_state)
      S_INIT: begin
        for (int i = 0; i < int'(NS); i++) w_cnt_nxt[i] = '0;
        if (w_tick) begin
          // Initial window ends: adopt synchronised levels silently.
          if (r_init_cnt == CNT_W'(DEBOUNCE_CNT - 1)) begin
            w_stable_nxt = w_sn;
            w_valid_nxt  = 1'b1;
            w_init_nxt   = '0;
            w_state_nxt  = S_RUN;
          end else begin
            w_init_nxt = r_init_cnt + CNT_W'(1);
          end
        end
      end
      S_RUN: begin
        for (int i = 0; i < int'(NS); i++) begin
          if (w_sn[i] == r_stable[i]) begin
            w_cnt_nxt[i] = '0;
          end else if (w_tick) begin
            if (r_cnt[i] == CNT_W'(DEBOUNCE_CNT - 1)) begin
              w_stable_nxt[i] = w_sn[i];
              w_cnt_nxt[i]    = '0;
              w_change_nxt[i] = 1'b1;
            end else begin
              w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
            end
          end
        end
      end
      default: w_state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_init_cnt <= '0;
      r_stable   <= '0;
      r_valid    <= 1'b0;
      r_change   <= '0;
      for (int i = 0; i < int'(NS); i++) r_cnt[i] <= '0;
    end else begin
      r_init_cnt <= w_init_nxt;
      r_stable   <= w_stable_nxt;
      r_valid    <= w_valid_nxt;
      r_change   <= w_change_nxt;
      for (int i = 0; i < int'(NS); i++) r_cnt[i] <= w_cnt_nxt[i];
    end
  end

  assign front_sensor  = r_stable[3];
  assign left_sensor   = r_stable[2];
  assign right_sensor  = r_stable[1];
  assign back_sensor   = r_stable[0];
  assign sensor_valid  = r_valid;
  assign sensor_change = r_change;

endmodule

// File: tb/tb_sensor_debounce.sv
// Directed bench for sensor_debounce with PRESCALE=4, DEBOUNCE_CNT=3, SYNC_STAGES=2.
module tb_sensor_debounce;

  logic       clk;
  logic       reset;
  logic       front_raw, left_raw, right_raw, back_raw;
  logic       front_sensor, left_sensor, right_sensor, back_sensor;
  logic       sensor_valid;
  logic [3:0] sensor_change;

  int n_checks = 0;
  int n_pass   = 0;

  sensor_debounce #(
    .SYNC_STAGES (2),
    .PRESCALE    (4),
    .PRESCALE_W  (2),
    .DEBOUNCE_CNT(3),
    .CNT_W       (2)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .front_raw    (front_raw),
    .left_raw     (left_raw),
    .right_raw    (right_raw),
    .back_raw     (back_raw),
    .front_sensor (front_sensor),
    .left_sensor  (left_sensor),
    .right_sensor (right_sensor),
    .back_sensor  (back_sensor),
    .sensor_valid (sensor_valid),
    .sensor_change(sensor_change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  // Advance n rising edges and settle just after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] sens();
    return {front_sensor, left_sensor, right_sensor, back_sensor};
  endfunction

  initial begin
    int   lat;
    logic any_chg;
    logic any_left;

    reset = 1'b0;
    {front_raw, left_raw, right_raw, back_raw} = 4'b0000;

    // 1: reset state and initial window (3 ticks of 4 clk -> 12 edges)
    step(2);
    check("rst_sens",  sens(), 4'b0000);
    check("rst_valid", 4'(sensor_valid), 4'd0);
    check("rst_chg",   sensor_change, 4'b0000);
    reset = 1'b1;
    step(11);
    check("t1_valid_early", 4'(sensor_valid), 4'd0);
    step(1);
    check("t1_valid",  4'(sensor_valid), 4'd1);
    check("t1_sens",   sens(), 4'b0000);
    check("t1_chg",    sensor_change, 4'b0000);

    // 2: front rises and is held; flip lands 11..14 edges later
    front_raw = 1'b1;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      step(1);
      if (front_sensor) begin lat = k; break; end
    end
    check("t2_lat",    4'(lat >= 11 && lat <= 14), 4'd1);
    check("t2_chg",    sensor_change, 4'b1000);
    step(1);
    check("t2_chg_end", sensor_change, 4'b0000);
    check("t2_sens",   sens(), 4'b1000);

    // 3: left glitch of 6 clk spans at most 2 ticks -> rejected
    left_raw = 1'b1;
    step(6);
    left_raw = 1'b0;
    any_chg = 1'b0;
    any_left = 1'b0;
    for (int k = 0; k < 30; k++) begin
      step(1);
      any_chg  = any_chg | (|sensor_change);
      any_left = any_left | left_sensor;
    end
    check("t3_left", 4'(any_left), 4'd0);
    check("t3_chg",  4'(any_chg), 4'd0);

    // 4a: front falls
    front_raw = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      step(1);
      if (!front_sensor) begin lat = k; break; end
    end
    check("t4_fall_lat", 4'(lat >= 11 && lat <= 14), 4'd1);
    check("t4_fall_chg", sensor_change, 4'b1000);
    step(1);

    // 4b: front and right rise together -> single joint pulse
    front_raw = 1'b1;
    right_raw = 1'b1;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      step(1);
      if (sensor_change != 4'b0000) begin lat = k; break; end
    end
    check("t4_lat",  4'(lat >= 11 && lat <= 14), 4'd1);
    check("t4_chg",  sensor_change, 4'b1010);
    check("t4_sens", sens(), 4'b1010);
    step(1);
    check("t4_chg_end", sensor_change, 4'b0000);

    // 5a: back high during INIT -> loaded at valid without a pulse
    front_raw = 1'b0;
    right_raw = 1'b0;
    back_raw  = 1'b1;
    reset = 1'b0;
    #1;
    check("t5_rst_sens",  sens(), 4'b0000);
    check("t5_rst_valid", 4'(sensor_valid), 4'd0);
    step(2);
    reset = 1'b1;
    step(11);
    check("t5_init_sens",  sens(), 4'b0000);
    check("t5_init_valid", 4'(sensor_valid), 4'd0);
    step(1);
    check("t5_valid", 4'(sensor_valid), 4'd1);
    check("t5_sens",  sens(), 4'b0001);
    check("t5_chg",   sensor_change, 4'b0000);
    step(1);
    check("t5_chg_next", sensor_change, 4'b0000);

    // 5b: reset in the middle of a front debounce
    front_raw = 1'b1;
    step(8);
    check("t5_pending", sens(), 4'b0001);
    reset = 1'b0;
    #1;
    check("t5_mid_sens",  sens(), 4'b0000);
    check("t5_mid_valid", 4'(sensor_valid), 4'd0);
    check("t5_mid_chg",   sensor_change, 4'b0000);
    step(2);
    reset = 1'b1;
    step(11);
    check("t5_re_early", 4'(sensor_valid), 4'd0);
    check("t5_re_sens0", sens(), 4'b0000);
    step(1);
    check("t5_re_valid", 4'(sensor_valid), 4'd1);
    check("t5_re_sens",  sens(), 4'b1001);
    check("t5_re_chg",   sensor_change, 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
